psad_accum_ctrl: RTL and testbench
==================================

// Module: psad_accum_ctrl
// PURPOSE
//  Sequences the per-pixel PSAD adder over one block: clears the partial-SAD register
//  bank, feeds ROWS_PER_BLOCK addend batches through the external adder (ready/valid),
//  then presents the finished PSAD vector downstream until it is taken.
//  Sits between the absolute-difference stage and the SAD compare/merge stage.
// PARAMETERS
//  PIXELS_IN_BATCH   16  lanes per batch
//  PSAD_BIT_DEPTH    14  width of each partial-SAD lane
//  ADDEND_BIT_DEPTH  11  width of each addend lane
//  ROWS_PER_BLOCK    16  batches accumulated per block (>=1)
// PORTS
//  clk             in   1                   clock, rising edge
//  rst_n           in   1                   async active-low reset
//  start           in   1                   begin a new block (see rules)
//  abort           in   1                   sync abort, back to IDLE
//  in_valid        in   1                   addend batch valid
//  in_ready        out  1                   controller accepts batch
//  in_addend       in   P*ADDEND_BIT_DEPTH  addend batch, lane i at [i*A +: A]
//  psad_ad_input   out  P*PSAD_BIT_DEPTH    to adder: current accumulator
//  psad_ad_addend  out  P*ADDEND_BIT_DEPTH  to adder: in_addend passed through
//  psad_ad_output  in   P*PSAD_BIT_DEPTH    from adder: lane-wise sum
//  out_valid       out  1                   psad_out holds finished block
//  out_ready       in   1                   downstream takes psad_out
//  psad_out        out  P*PSAD_BIT_DEPTH    finished PSAD vector
//  busy            out  1                   state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=0, row_cnt=0; in_ready=0, out_valid=0,
//   busy=0, psad_out=0. psad_ad_input=acc, psad_ad_addend=in_addend always (comb).
//  States: IDLE, ACCUM, HOLD. in_ready=(state==ACCUM); out_valid=(state==HOLD).
//  IDLE: start=1 -> ACCUM next cycle, acc<=0, row_cnt<=0. in_valid ignored.
//  ACCUM: accept = in_valid & in_ready. On accept acc<=psad_ad_output (adder is
//   comb, 0 cycles), row_cnt<=row_cnt+1. On accept with row_cnt==ROWS_PER_BLOCK-1:
//   -> HOLD, psad_out <= psad_ad_output (final sum incl. last batch), row_cnt<=0.
//   No accept: hold everything. start ignored in ACCUM.
//  HOLD: psad_out stable while out_valid & !out_ready. out_ready=1: if start=1 same
//   cycle -> ACCUM with acc<=0 (back-to-back, no IDLE bubble) else -> IDLE.
//   start without out_ready is ignored (not latched).
//  abort=1 in any state: -> IDLE, acc<=0, row_cnt<=0, out_valid drops next cycle;
//   abort has priority over start, accept and out_ready.
//  Arithmetic: lane-wise modulo 2^PSAD_BIT_DEPTH, zero-extended addend, no saturation;
//   lanes independent (no carry between lanes).
//  Latency: start to first in_ready = 1 cycle; last accept to out_valid = 1 cycle;
//   minimum block period ROWS_PER_BLOCK+1 cycles with back-to-back start.
//  ROWS_PER_BLOCK=1: first accept goes straight to HOLD.
//  row_cnt width clog2(ROWS_PER_BLOCK+1); never exceeds ROWS_PER_BLOCK-1.
// TESTING
//  1 reset mid-ACCUM after 5 accepts -> all outputs 0 immediately; next start restarts
//    with acc=0.
//  2 start, 16 batches all lanes=3, in_valid continuous -> out_valid on cycle 17
//    after start, every lane=48; out_ready=1 -> IDLE.
//  3 in_valid toggled 1/0, lane i addend=i -> exactly 16 accepts counted, lane i=16*i.
//  4 lane 0 addend=2047 x16 -> lane 0 = 32752 mod 16384 = 16368 (wrap), other lanes
//    unaffected.
//  5 out_ready held 0 for 10 cycles in HOLD -> psad_out stable, in_ready=0; then
//    out_ready=1 with start=1 -> ACCUM next cycle, acc=0.
//  6 abort asserted with in_valid on last row -> no out_valid, IDLE next cycle.

Source files
------------

// File: rtl/psad_accum_ctrl.sv
// psad_accum_ctrl
//   Sequences the lane-wise PSAD adder over one block. The block starts by clearing
//   the partial-SAD accumulator. It then accepts ROWS_PER_BLOCK addend batches through
//   a ready/valid input and feeds each batch, together with the accumulator, to an
//   external combinational adder. When the block is complete, the finished PSAD vector
//   is held on psad_out until downstream takes it.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a new block (accepted in IDLE, or in HOLD together with out_ready)
//   abort           synchronous abort back to IDLE (highest priority)
//   in_valid        addend batch valid
//   in_ready        batch accepted this cycle when in_valid is also high (high in ACCUM)
//   in_addend       addend batch, lane i at [i*ADDEND_BIT_DEPTH +: ADDEND_BIT_DEPTH]
//   psad_ad_input   to adder: current accumulator
//   psad_ad_addend  to adder: in_addend passed straight through
//   psad_ad_output  from adder: lane-wise sum, same cycle
//   out_valid       psad_out holds a finished block (HOLD)
//   out_ready       downstream takes psad_out
//   psad_out        finished PSAD vector
//   busy            controller is not idle
module psad_accum_ctrl #(
  parameter int PIXELS_IN_BATCH  = 16,
  parameter int PSAD_BIT_DEPTH   = 14,
  parameter int ADDEND_BIT_DEPTH = 11,
  parameter int ROWS_PER_BLOCK   = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [PIXELS_IN_BATCH*ADDEND_BIT_DEPTH-1:0] in_addend,
  output logic [PIXELS_IN_BATCH*PSAD_BIT_DEPTH-1:0]   psad_ad_input,
  output logic [PIXELS_IN_BATCH*ADDEND_BIT_DEPTH-1:0] psad_ad_addend,
  input  logic [PIXELS_IN_BATCH*PSAD_BIT_DEPTH-1:0]   psad_ad_output,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PIXELS_IN_BATCH*PSAD_BIT_DEPTH-1:0]   psad_out,
  output logic                                     busy
);

  localparam int LW    = PIXELS_IN_BATCH * PSAD_BIT_DEPTH;
  localparam int CNT_W = $clog2(ROWS_PER_BLOCK + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [LW-1:0]    acc, acc_nxt;
  logic [LW-1:0]    psad_out_nxt;
  logic [CNT_W-1:0] row_cnt, row_cnt_nxt;
  logic             accept;

  assign in_ready       = (state == ACCUM);
  assign out_valid      = (state == HOLD);
  assign busy           = (state != IDLE);
  assign psad_ad_input  = acc;
  assign psad_ad_addend = in_addend;
  assign accept         = in_valid && in_ready;

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    row_cnt_nxt  = row_cnt;
    psad_out_nxt = psad_out;
    if (abort) begin
      state_nxt   = IDLE;
      acc_nxt     = '0;
      row_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt   = ACCUM;
            acc_nxt     = '0;
            row_cnt_nxt = '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_nxt = psad_ad_output;
            if (row_cnt == LAST_ROW) begin
              // The last sum goes straight to psad_out, so it includes the final batch
              // without waiting an extra cycle.
              state_nxt    = HOLD;
              psad_out_nxt = psad_ad_output;
              row_cnt_nxt  = '0;
            end else begin
              row_cnt_nxt = row_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) begin
              // Back-to-back block: no IDLE bubble between blocks.
              state_nxt   = ACCUM;
              acc_nxt     = '0;
              row_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          acc_nxt     = '0;
          row_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      row_cnt  <= '0;
      psad_out <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      row_cnt  <= row_cnt_nxt;
      psad_out <= psad_out_nxt;
    end
  end

endmodule

// File: tb/tb_psad_accum_ctrl.sv
module tb_psad_accum_ctrl;

  localparam int P  = 16;
  localparam int S  = 14;
  localparam int A  = 11;
  localparam int R  = 16;
  localparam int LW = P * S;
  localparam int AW = P * A;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, in_valid, in_ready, out_valid, out_ready, busy;
  logic [AW-1:0] in_addend, ad_addend;
  logic [LW-1:0] ad_in, ad_out, psad_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int hs_cnt = 0;
  logic [LW-1:0] exp_q[$];

  psad_accum_ctrl #(
    .PIXELS_IN_BATCH (P),
    .PSAD_BIT_DEPTH  (S),
    .ADDEND_BIT_DEPTH(A),
    .ROWS_PER_BLOCK  (R)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addend     (in_addend),
    .psad_ad_input (ad_in),
    .psad_ad_addend(ad_addend),
    .psad_ad_output(ad_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .psad_out      (psad_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // External lane-wise adder: zero-extended addend, modulo 2^S, no carry between lanes.
  always_comb begin
    ad_out = '0;
    for (int unsigned i = 0; i < P; i++)
      ad_out[i*S +: S] = ad_in[i*S +: S] + S'(ad_addend[i*A +: A]);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lane_val(int mode, int row, int lane);
    case (mode)
      0:       return 3;
      1:       return lane;
      2:       return (lane == 0) ? 2047 : 5;
      default: return ((row * 37 + lane * 101 + 13) ^ (row << 3)) & 2047;
    endcase
  endfunction

  function automatic logic [AW-1:0] batch(int mode, int row);
    logic [AW-1:0] b;
    b = '0;
    for (int lane = 0; lane < P; lane++) b[lane*A +: A] = A'(lane_val(mode, row, lane));
    return b;
  endfunction

  function automatic logic [LW-1:0] model(int mode);
    logic [LW-1:0] m;
    int s;
    m = '0;
    for (int lane = 0; lane < P; lane++) begin
      s = 0;
      for (int row = 0; row < R; row++) s += lane_val(mode, row, lane);
      m[lane*S +: S] = S'(s % (1 << S));
    end
    return m;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard side: count input handshakes, pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
      else chk("sb_psad", psad_out, exp_q.pop_front());
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int mode, input bit toggle, input int rows);
    int  cyc;
    int  accepts;
    bit  ph;
    cyc = 0; accepts = 0; ph = 1'b1;
    while (accepts < rows && cyc < 200) begin
      in_valid  = toggle ? ph : 1'b1;
      ph        = !ph;
      in_addend = batch(mode, accepts);
      @(negedge clk);
      if (in_valid && in_ready) accepts++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (accepts < rows) chk("feed_timeout", accepts, rows);
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int h0;
    int bad;
    logic [LW-1:0] snap;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addend = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_psad_out", psad_out, 0);
    chk("rst_acc", ad_in, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: reset in the middle of ACCUM after 5 accepts.
    do_start();
    feed(0, 1'b0, 5);
    chk("acc_5rows", ad_in, {P{S'(15)}});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_acc", ad_in, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 2: continuous block of 3s, latency and return to IDLE.
    out_ready = 1'b1;
    exp_q.push_back(model(0));
    s0 = cyc_cnt;
    do_start();
    feed(0, 1'b0, R);
    @(negedge clk);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_latency", cyc_cnt - s0, 17);
    chk("t2_lane7", psad_out[7*S +: S], 48);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_idle", busy, 0);
    @(posedge clk); #1;

    // Test 3: toggled in_valid, lane i = i; exactly R accepts.
    out_ready = 1'b0;
    exp_q.push_back(model(1));
    h0 = hs_cnt;
    do_start();
    feed(1, 1'b1, R);
    repeat (6) begin
      in_valid = !in_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepts", hs_cnt - h0, R);
    chk("t3_in_ready_hold", in_ready, 0);
    chk("t3_lane15", psad_out[15*S +: S], 240);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Test 4: lane 0 wraps modulo 2^S, other lanes independent.
    exp_q.push_back(model(2));
    do_start();
    feed(2, 1'b0, R);
    @(negedge clk);
    chk("t4_wrap_lane0", psad_out[S-1:0], 16368);
    chk("t4_lane1", psad_out[S +: S], 80);
    drain();

    // Test 5: stall in HOLD, then back-to-back start with out_ready.
    out_ready = 1'b0;
    exp_q.push_back(model(3));
    do_start();
    feed(3, 1'b0, R);
    @(negedge clk);
    snap = psad_out;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (psad_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("t5_hold_stable", bad, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(model(1));
    do_start();
    chk("t5_b2b_in_ready", in_ready, 1);
    chk("t5_b2b_acc_clr", ad_in, 0);
    feed(1, 1'b0, R);
    drain();
    chk("t5_idle", busy, 0);

    // Test 6: abort on the last row beats the accept.
    do_start();
    feed(0, 1'b0, R - 1);
    in_valid  = 1'b1;
    abort     = 1'b1;
    in_addend = batch(0, R - 1);
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_acc", ad_in, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("t6_no_valid", bad, 0);
    @(posedge clk); #1;
    exp_q.push_back(model(0));
    do_start();
    feed(0, 1'b0, R);
    drain();

    chk("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
